// File: rtl/vec_pkg.sv
// Shared types for the XY vector stepper.
//   coord_t     : 13-bit unsigned beam coordinate
//   intens_t    : 4-bit beam intensity (0 = blanked)
//   vec_state_e : stepper control states
package vec_pkg;

    localparam int COORD_W = 13;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [3:0]         intens_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BLANK,
        SETTLE,
        DRAW
    } vec_state_e;

endpackage

// File: rtl/vec_dda_step.sv
// One Bresenham step, purely combinational.
// Ports:
//   curX, curY     : current beam point
//   err            : current decision variable (signed)
//   xMajor         : 1 when X is the major (always stepping) axis
//   xNeg, yNeg     : direction flags (1 = decreasing coordinate)
//   dx, dy         : absolute axis deltas of the segment
//   nextX, nextY   : point after one step
//   nextErr        : decision variable after one step
module vec_dda_step
    import vec_pkg::*;
(
    input  coord_t             curX,
    input  coord_t             curY,
    input  logic signed [14:0] err,
    input  logic               xMajor,
    input  logic               xNeg,
    input  logic               yNeg,
    input  logic [13:0]        dx,
    input  logic [13:0]        dy,
    output coord_t             nextX,
    output coord_t             nextY,
    output logic signed [14:0] nextErr
);

    logic [13:0]        major;
    logic [13:0]        minor;
    logic               minorStep;
    logic               stepX;
    logic               stepY;
    logic signed [15:0] errWide;

    always_comb begin
        major     = xMajor ? dx : dy;
        minor     = xMajor ? dy : dx;
        // The minor axis moves once the accumulated error has gone positive;
        // ties (err == 0) stay put, so half-way points round toward the start.
        minorStep = (err > 15'sd0);
        stepX     = xMajor | minorStep;
        stepY     = ~xMajor | minorStep;

        errWide = $signed({err[14], err}) + $signed({1'b0, minor, 1'b0});
        if (minorStep) begin
            errWide = errWide - $signed({1'b0, major, 1'b0});
        end
        // err stays within (-2*major, 2*minor], which always fits 15 bits.
        nextErr = errWide[14:0];

        nextX = curX;
        if (stepX) begin
            nextX = xNeg ? (curX - coord_t'(1)) : (curX + coord_t'(1));
        end
        nextY = curY;
        if (stepY) begin
            nextY = yNeg ? (curY - coord_t'(1)) : (curY + coord_t'(1));
        end
    end

endmodule

// File: rtl/vec_xy_stepper.sv
// XY vector stepper: pops line segments from the line-register queue and
// steps the beam along each with an integer Bresenham DDA, producing a
// valid/ready stream of X/Y/Z points for an XY vector DAC. Disjoint segments
// are preceded by a blanked move to the segment start.
// Build option: define VEC_SETTLE_EN to insert SETTLE_CYCLES idle cycles
// after every blanked move so the deflection amplifiers can settle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   q_start_x/y, q_end_x/y, q_intensity, q_empty : queue head
//   q_read              : one-cycle pop strobe
//   dac_x, dac_y, dac_z : beam point (top DAC_W coordinate bits, intensity)
//   dac_valid/dac_ready : point handshake
//   line_done           : one-cycle pulse after a segment's last point
//   busy                : stepper not idle
module vec_xy_stepper
    import vec_pkg::*;
#(
    parameter int DAC_W         = 10,
    parameter int STEP_DIV      = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  coord_t           q_start_x,
    input  coord_t           q_start_y,
    input  coord_t           q_end_x,
    input  coord_t           q_end_y,
    input  intens_t          q_intensity,
    input  logic             q_empty,
    output logic             q_read,
    output logic [DAC_W-1:0] dac_x,
    output logic [DAC_W-1:0] dac_y,
    output logic [3:0]       dac_z,
    output logic             dac_valid,
    input  logic             dac_ready,
    output logic             line_done,
    output logic             busy
);

    if (STEP_DIV < 1 || SETTLE_CYCLES < 1) begin : gParamCheck
        $error("vec_xy_stepper: STEP_DIV and SETTLE_CYCLES must be >= 1");
    end

    localparam int RATE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    vec_state_e         state;
    vec_state_e         nextState;
    logic [RATE_W-1:0]  rateCnt;
    coord_t             bx, by;
    coord_t             sx, sy, ex, ey;
    intens_t            latI;
    coord_t             curX, curY;
    logic               xNeg, yNeg, xMajor;
    logic [13:0]        dx, dy, stepsLeft;
    logic signed [14:0] err;
    logic               lineDone;
    logic               qRead;
    logic               xfer;
    logic               needBlank;

    logic [13:0]        fDx, fDy, fMinor, fSteps;
    logic               fXNeg, fYNeg, fXMajor;
    logic signed [14:0] fErr;

    coord_t             nextX, nextY;
    logic signed [14:0] nextErr;
    coord_t             ptX, ptY;
    intens_t            ptZ;

    vec_dda_step uDda (
        .curX    (curX),
        .curY    (curY),
        .err     (err),
        .xMajor  (xMajor),
        .xNeg    (xNeg),
        .yNeg    (yNeg),
        .dx      (dx),
        .dy      (dy),
        .nextX   (nextX),
        .nextY   (nextY),
        .nextErr (nextErr)
    );

    // Segment setup, evaluated from the latched queue entry during FETCH.
    always_comb begin
        fXNeg   = (ex < sx);
        fYNeg   = (ey < sy);
        fDx     = fXNeg ? {1'b0, sx - ex} : {1'b0, ex - sx};
        fDy     = fYNeg ? {1'b0, sy - ey} : {1'b0, ey - sy};
        fXMajor = (fDx >= fDy);
        fSteps  = fXMajor ? fDx : fDy;
        fMinor  = fXMajor ? fDy : fDx;
        fErr    = $signed({fMinor, 1'b0}) - $signed({1'b0, fSteps});
    end

    // Moves (intensity 0) jump straight to their end point, so they never blank.
    assign needBlank = ((sx != bx) || (sy != by)) && (latI != '0);

    // A point is offered only once the rate counter has run out.
    assign dac_valid = ((state == BLANK) || (state == DRAW)) && (rateCnt == '0);
    assign xfer      = dac_valid && dac_ready;

    always_comb begin
        ptX = curX;
        ptY = curY;
        ptZ = latI;
        if (state == BLANK) begin
            ptX = sx;
            ptY = sy;
            ptZ = '0;
        end
    end

    assign dac_x     = dac_valid ? ptX[COORD_W-1 -: DAC_W] : '0;
    assign dac_y     = dac_valid ? ptY[COORD_W-1 -: DAC_W] : '0;
    assign dac_z     = dac_valid ? ptZ : '0;
    assign q_read    = qRead;
    assign line_done = lineDone;
    assign busy      = (state != IDLE);

`ifdef VEC_SETTLE_EN
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    logic [SET_W-1:0] settleCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            settleCnt <= '0;
        end else if ((state == BLANK) && xfer) begin
            settleCnt <= SET_W'(SETTLE_CYCLES - 1);
        end else if ((state == SETTLE) && (settleCnt != '0)) begin
            settleCnt <= settleCnt - SET_W'(1);
        end
    end
`endif

    always_comb begin
        nextState = state;
        qRead     = 1'b0;
        case (state)
            IDLE: begin
                // Hold off one cycle while line_done pulses so the next pop
                // lands strictly after it.
                if (!q_empty && !lineDone) begin
                    qRead     = 1'b1;
                    nextState = FETCH;
                end
            end
            FETCH: begin
                nextState = needBlank ? BLANK : DRAW;
            end
            BLANK: begin
                if (xfer) begin
`ifdef VEC_SETTLE_EN
                    nextState = SETTLE;
`else
                    nextState = DRAW;
`endif
                end
            end
            SETTLE: begin
`ifdef VEC_SETTLE_EN
                if (settleCnt == '0) begin
                    nextState = DRAW;
                end
`else
                nextState = DRAW;
`endif
            end
            DRAW: begin
                if (xfer && (stepsLeft == '0)) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Control: state, rate limiter, beam position, completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rateCnt  <= '0;
            bx       <= '0;
            by       <= '0;
            lineDone <= 1'b0;
        end else begin
            state    <= nextState;
            lineDone <= (state == DRAW) && xfer && (stepsLeft == '0);
            if (xfer) begin
                rateCnt <= RATE_W'(STEP_DIV - 1);
            end else if (rateCnt != '0) begin
                rateCnt <= rateCnt - RATE_W'(1);
            end
            if (xfer) begin
                bx <= (state == BLANK) ? sx : curX;
                by <= (state == BLANK) ? sy : curY;
            end
        end
    end

    // Segment datapath: queue latch, DDA setup and stepping.
    always_ff @(posedge clk) begin
        if (qRead) begin
            sx   <= q_start_x;
            sy   <= q_start_y;
            ex   <= q_end_x;
            ey   <= q_end_y;
            latI <= q_intensity;
        end
        if (state == FETCH) begin
            xNeg   <= fXNeg;
            yNeg   <= fYNeg;
            xMajor <= fXMajor;
            dx     <= fDx;
            dy     <= fDy;
            err    <= fErr;
            if (latI == '0) begin
                curX      <= ex;
                curY      <= ey;
                stepsLeft <= '0;
            end else begin
                curX      <= sx;
                curY      <= sy;
                stepsLeft <= fSteps;
            end
        end
        if ((state == DRAW) && xfer && (stepsLeft != '0)) begin
            curX      <= nextX;
            curY      <= nextY;
            err       <= nextErr;
            stepsLeft <= stepsLeft - 14'd1;
        end
    end

endmodule
